// File: rtl/common_pkg.sv
// Shared types for the dual-core MSI system.
//   blk_state_t : per-line MSI coherence state used by the cache controllers.
//   arb_state_t : ownership state of the unified-memory arbiter.
//   CORE0/CORE1 : core ids as used by grant/owner/rr pointer.
package common;

    typedef enum logic [1:0] {
        BLK_INVALID,
        BLK_SHARED,
        BLK_MODIFIED
    } blk_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN0,
        ARB_OWN1,
        ARB_GAP
    } arb_state_t;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

endpackage

// File: rtl/umem_arbiter.sv
// Two-requester round-robin arbiter for the shared unified memory port.
// Ownership is held for as long as the owner keeps re or we asserted, so a
// write-back followed by a fill is never split. A one-cycle gap follows every
// release. A sticky hold_err flags any ownership lasting HOLD_MAX cycles.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   u_re, u_we [1:0]      per-core read / write requests (levels)
//   u_addr0/1, d_line0/1  per-core line address / write data
//   grant [1:0]           one-hot ownership (decoded from state register)
//   u_rdy [1:0]           mem_rdy steered to the owner only
//   u_rd_data             mem_rdata broadcast to both cores
//   mem_re/we/addr/wdata  muxed request to unified memory
//   mem_rdy, mem_rdata    memory response
//   owner                 id of current or last owner
//   hold_err              sticky hold-limit violation
module umem_arbiter
    import common::*;
#(
    parameter int unsigned HOLD_MAX = 64,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  u_re,
    input  logic [1:0]  u_we,
    input  logic [10:0] u_addr0,
    input  logic [10:0] u_addr1,
    input  logic [63:0] d_line0,
    input  logic [63:0] d_line1,
    output logic [1:0]  grant,
    output logic [1:0]  u_rdy,
    output logic [63:0] u_rd_data,
    output logic        mem_re,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_rdy,
    input  logic [63:0] mem_rdata,
    output logic        owner,
    output logic        hold_err
);

    localparam logic [CNT_W-1:0] HoldLimit = CNT_W'(HOLD_MAX);

    arb_state_t       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_err_q, hold_err_d;

    logic [1:0] req;
    logic       pick;
    logic       own_keep;

    assign req = u_re | u_we;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        hold_err_d = hold_err_q;
        pick       = CORE0;
        own_keep   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (req != 2'b00) begin
                    // Tie goes to rr_ptr; otherwise the single requester wins.
                    pick       = (req == 2'b11) ? rr_ptr_q : req[1];
                    state_d    = (pick == CORE1) ? ARB_OWN1 : ARB_OWN0;
                    owner_d    = pick;
                    rr_ptr_d   = ~pick;
                    // First OWN cycle counts as one held cycle.
                    hold_cnt_d = CNT_W'(1);
                end
            end
            ARB_OWN0: begin
                own_keep = req[0];
            end
            ARB_OWN1: begin
                own_keep = req[1];
            end
            ARB_GAP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (state_q == ARB_OWN0 || state_q == ARB_OWN1) begin
            if (own_keep) begin
                hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + 1'b1;
                // Registered so hold_err is high in the cycle the count equals HOLD_MAX.
                if (hold_cnt_d == HoldLimit) begin
                    hold_err_d = 1'b1;
                end
            end else begin
                state_d = ARB_GAP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= CORE0;
            owner_q    <= CORE0;
            hold_cnt_q <= '0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            hold_err_q <= hold_err_d;
        end
    end

    // Memory-side mux; everything is zero outside the OWN states.
    always_comb begin
        grant     = 2'b00;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            ARB_OWN0: begin
                grant     = 2'b01;
                mem_re    = u_re[0];
                mem_we    = u_we[0];
                mem_addr  = u_addr0;
                mem_wdata = d_line0;
            end
            ARB_OWN1: begin
                grant     = 2'b10;
                mem_re    = u_re[1];
                mem_we    = u_we[1];
                mem_addr  = u_addr1;
                mem_wdata = d_line1;
            end
            default: begin
            end
        endcase
    end

    assign u_rdy     = grant & {2{mem_rdy}};
    assign u_rd_data = mem_rdata;
    assign owner     = owner_q;
    assign hold_err  = hold_err_q;

endmodule

// File: doc/umem_arbiter.md
# umem_arbiter

Two-requester arbiter for the shared unified (off-cache) memory port in the dual-core MSI system. It sits between the two per-core cache controllers and the single unified memory. It grants exclusive memory ownership to one core at a time with round-robin fairness, and holds ownership across a complete evict-plus-fill sequence. It muxes address, data and enables to memory, steers the memory ready back to the owner only, and flags any owner that holds the bus past a programmable limit.

## Interface
Parameters:
- HOLD_MAX, default 64: owner-hold cycle limit before `hold_err` sets (≥2).
- CNT_W, default 8: width of hold counter; must hold HOLD_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- u_re  in  2  per-core memory read request (bit i = core i), level.
- u_we  in  2  per-core memory write request, level.
- u_addr0 / u_addr1  in  11  per-core line address.
- d_line0 / d_line1  in  64  per-core write line.
- grant  out  2  one-hot ownership, registered.
- u_rdy  out  2  per-core ready: bit i = mem_rdy & grant[i].
- u_rd_data  out  64  mem_rdata broadcast to both cores.
- mem_re, mem_we  out  1  to unified memory.
- mem_addr  out  11  to unified memory.
- mem_wdata  out  64  to unified memory.
- mem_rdy  in  1  memory done/ready.
- mem_rdata  in  64  memory read line.
- owner  out  1  id of current or last owner.
- hold_err  out  1  sticky: some owner exceeded HOLD_MAX.

## Operation
- State machine `arb_state_t`: ARB_IDLE, ARB_OWN0, ARB_OWN1, ARB_GAP.
- `rr_ptr` (1 bit): core favoured on a tie. Reset value is 0.
- In ARB_IDLE, a core is requesting if `u_re[i] | u_we[i]`.
  - Only one core requesting: go to ARB_OWNi.
  - Both requesting: go to ARB_OWN{rr_ptr}.
  - On every grant, `rr_ptr` loads the id of the other core.
- In ARB_OWNi:
  - `grant[i]`=1.
  - mem_re/mem_we/mem_addr/mem_wdata = core i's u_re/u_we/u_addrI/d_lineI (combinational mux on state).
  - The other core's requests are ignored and its u_rdy stays 0.
  - If the owner drops both re and we, go to ARB_GAP.
- Ownership is not released between write-back and fill. Re and we may switch in the same cycle, or both stay asserted, and the owner keeps the grant.
- ARB_GAP:
  - Exactly one cycle.
  - grant=0, mem_re=mem_we=0.
  - Then go to ARB_IDLE.
- Outside the OWN states: mem_re=mem_we=0, mem_addr=0, mem_wdata=0.
- If mem_re and mem_we are both high from the owner, both are forwarded unchanged. Memory gives write priority.
- Hold counter:
  - Clears on entry to an OWN state and increments each OWN cycle; it saturates at all-ones.
  - When the count reaches HOLD_MAX while in OWN, `hold_err` sets.
  - `hold_err` clears only on reset.
  - Grant is never revoked because of `hold_err`.
- `owner` updates on each grant and holds its value through GAP/IDLE.

## Timing
- Reset values: state ARB_IDLE, grant 2'b00, rr_ptr 0, owner 0, hold counter 0, hold_err 0.
- Reset is asynchronous. Asserting it mid-transaction drops grant and the mem enables immediately. The in-flight memory access is abandoned.
- Grant latency: a request seen in IDLE at edge N gives grant high after edge N, visible in cycle N+1.
- Best-case latency from request to first mem_re is 1 cycle.
- u_rdy is combinational from mem_rdy, zero-cycle.
- Release:
  - Owner deasserts in cycle K; GAP is cycle K+1.
  - Next grant is no earlier than cycle K+3 (IDLE at K+2).
  - Minimum turnaround between owners is 2 dead cycles.
- A new request that arrives during GAP waits for IDLE; it is not lost, since requests are levels.
- A core that drops its request in IDLE before being granted is simply not granted. No state is retained.

## Structure
- Add `arb_state_t` and `localparam CORE0=1'b0, CORE1=1'b1` to package `common`, alongside `blk_state_t`.
- Single flat module; no sub-module needed. The hold counter and the rr pointer are inline registers.
- Each cache controller's `grant` connects to `grant[i]`, and its `u_rdy` to `u_rdy[i]`.

## Test plan
- Reset, then core0 u_re=1, u_addr0=11'h055 → grant=2'b01 next cycle. mem_re=1, mem_addr=11'h055. When mem_rdy=1 with mem_rdata=64'hDEAD_BEEF_0123_4567: u_rdy=2'b01 and u_rd_data matches.
- Both cores raise u_re in the same cycle after reset → core0 granted first (rr_ptr=0). After core0 releases: one GAP, one IDLE, then grant=2'b10.
- Core1 evict then fill: u_we=1 with u_addr1=11'h7F0; on mem_rdy, switch to u_re=1 with u_addr1=11'h010 in the same cycle → grant stays 2'b10 throughout. Core0's concurrent request stays ungranted and its u_rdy stays 0.
- Core0 holds u_re for HOLD_MAX=8 cycles with mem_rdy=0 → hold_err rises on the 8th OWN cycle, stays 1 after release, and grant is still 2'b01 while held.
- rst_n pulled low mid-OWN1 → grant, mem_re and mem_we go to 0 asynchronously. After release of reset, state is IDLE and a core1 request is granted next cycle.
- Core0 requests continuously while core1 issues repeated single reads → grants alternate 01/10 and neither core is starved.
